// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the CPU data-memory responder:
//   - default address map (RAM base, tohost register)
//   - address-class enum used by the request decoder
//   - write-buffer entry layout
// No ports (package).
// -----------------------------------------------------------------------------
package data_mem_pkg;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_F000;

  // Widest word index a 32-bit byte address can produce. The buffer entry is
  // sized for this so the typedef does not depend on DEPTH; the buffer
  // zero-extends narrower indices into it.
  localparam int unsigned WBUF_IDX_W = 30;

  typedef enum logic [1:0] {
    ACC_RAM     = 2'd0,
    ACC_TOHOST  = 2'd1,
    ACC_ILLEGAL = 2'd2
  } acc_class_e;

  typedef struct packed {
    logic                  valid;
    logic [WBUF_IDX_W-1:0] index;
    logic [31:0]           data;
  } wbuf_entry_t;

endpackage

// File: rtl/data_mem_wbuf.sv
// -----------------------------------------------------------------------------
// data_mem_wbuf
// One-entry posted-store buffer. A RAM store parks {index, data} here; the
// previous entry (if any) is handed to the array on the same edge. With no
// new store the entry drains and the buffer empties. Loads see the parked
// entry through the bypass outputs.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_wr_en             RAM store this cycle
//   i_wr_idx/i_wr_data  word index / data of that store
//   i_rd_idx            word index of the current load
//   o_hit/o_hit_data    bypass: buffer holds a newer value for i_rd_idx
//   o_drain_we/_idx/_data  write port towards the RAM array
// -----------------------------------------------------------------------------
module data_mem_wbuf
  import data_mem_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_hit,
  output logic [31:0]      o_hit_data,
  output logic             o_drain_we,
  output logic [IDX_W-1:0] o_drain_idx,
  output logic [31:0]      o_drain_data
);

  wbuf_entry_t r_entry;

  // Reset clears valid, so a store still parked at reset never reaches the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entry <= '0;
    end else if (i_wr_en) begin
      r_entry.valid <= 1'b1;
      r_entry.index <= WBUF_IDX_W'(i_wr_idx);
      r_entry.data  <= i_wr_data;
    end else begin
      r_entry.valid <= 1'b0;
    end
  end

  // A valid entry is always committed on the next edge: either it is being
  // replaced by a new store or it is draining on an idle edge.
  assign o_drain_we   = r_entry.valid;
  assign o_drain_idx  = r_entry.index[IDX_W-1:0];
  assign o_drain_data = r_entry.data;

  assign o_hit      = r_entry.valid && (r_entry.index == WBUF_IDX_W'(i_rd_idx));
  assign o_hit_data = r_entry.data;

endmodule

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
// Responder end of the CPU data-memory port. Loads are combinational; RAM
// stores are posted through a one-entry write buffer with read-after-write
// bypass. Also holds the tohost halt register and a sticky illegal-access
// flag that records the first offending address.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   data_ce_i     access request this cycle
//   data_we_i     1 = store, 0 = load
//   data_addr_i   byte address
//   data_i        store data
//   data_o        load data (combinational, 0 when idle or illegal)
//   err_o         sticky illegal-access flag
//   err_addr_o    address of the first illegal access
//   halt_o        tohost written with bit0 = 1 (sticky)
//   tohost_o      last value written to tohost
// -----------------------------------------------------------------------------
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] TOHOST_ADDR = DEF_TOHOST_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic        halt_o,
  output logic [31:0] tohost_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  // ---------------- address decode ----------------
  // Offset is computed on 33 bits so addresses below BASE_ADDR cannot wrap
  // into the RAM window.
  logic [32:0]      w_offset;
  logic             w_in_ram;
  logic [IDX_W-1:0] w_idx;
  acc_class_e       w_class;

  assign w_offset = {1'b0, data_addr_i} - {1'b0, BASE_ADDR};
  assign w_in_ram = (data_addr_i >= BASE_ADDR) && (w_offset < RAM_BYTES) &&
                    (data_addr_i[1:0] == 2'b00);
  assign w_idx    = w_offset[IDX_W+1:2];

  always_comb begin
    w_class = ACC_ILLEGAL;
    if (w_in_ram)
      w_class = ACC_RAM;
    else if (data_addr_i == TOHOST_ADDR)
      w_class = ACC_TOHOST;
  end

  logic w_store_ram, w_store_tohost, w_illegal;
  assign w_store_ram    = data_ce_i && data_we_i && (w_class == ACC_RAM);
  assign w_store_tohost = data_ce_i && data_we_i && (w_class == ACC_TOHOST);
  assign w_illegal      = data_ce_i && (w_class == ACC_ILLEGAL);

  // ---------------- write buffer + array ----------------
  logic             w_hit, w_drain_we;
  logic [31:0]      w_hit_data, w_drain_data;
  logic [IDX_W-1:0] w_drain_idx;

  data_mem_wbuf #(.IDX_W(IDX_W)) u_wbuf (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (w_store_ram),
    .i_wr_idx     (w_idx),
    .i_wr_data    (data_i),
    .i_rd_idx     (w_idx),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data),
    .o_drain_we   (w_drain_we),
    .o_drain_idx  (w_drain_idx),
    .o_drain_data (w_drain_data)
  );

  // Contents are deliberately not reset.
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_drain_we)
      r_mem[w_drain_idx] <= w_drain_data;
  end

  // ---------------- tohost / error state ----------------
  logic        r_err, r_halt;
  logic [31:0] r_err_addr, r_tohost;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_halt     <= 1'b0;
      r_tohost   <= '0;
    end else begin
      if (w_illegal) begin
        r_err <= 1'b1;
        if (!r_err)
          r_err_addr <= data_addr_i;
      end
      if (w_store_tohost) begin
        r_tohost <= data_i;
        if (data_i[0])
          r_halt <= 1'b1;
      end
    end
  end

  assign err_o      = r_err;
  assign err_addr_o = r_err_addr;
  assign halt_o     = r_halt;
  assign tohost_o   = r_tohost;

  // ---------------- load data ----------------
  always_comb begin
    data_o = '0;
    if (data_ce_i && !data_we_i) begin
      unique case (w_class)
        ACC_RAM:    data_o = w_hit ? w_hit_data : r_mem[w_idx];
        ACC_TOHOST: data_o = r_tohost;
        default:    data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] TOHOST = 32'h0000_F000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, din = '0;
  logic [31:0] dout, err_addr, tohost;
  logic        err, halt;

  data_mem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TOHOST_ADDR(TOHOST)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_ce_i   (ce),
    .data_we_i   (we),
    .data_addr_i (addr),
    .data_i      (din),
    .data_o      (dout),
    .err_o       (err),
    .err_addr_o  (err_addr),
    .halt_o      (halt),
    .tohost_o    (tohost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model (architectural view) ----------------
  // A store is visible immediately to later loads and becomes permanent one
  // edge later; a reset inside that window undoes it.
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_err, m_halt;
  logic [31:0] m_err_addr, m_tohost;
  bit          p_valid, p_known;
  int          p_idx;
  logic [31:0] p_old;

  typedef struct {
    logic [31:0] exp;
    bit          chk;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  // 0 = RAM, 1 = TOHOST, 2 = ILLEGAL
  function automatic int addr_class(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off >= 0 && off < 4 * DEPTH && (off % 4) == 0) return 0;
    if (a == TOHOST) return 1;
    return 2;
  endfunction

  function automatic int addr_index(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    check("err_o", {31'd0, err}, {31'd0, m_err});
    check("err_addr_o", err_addr, m_err_addr);
    check("halt_o", {31'd0, halt}, {31'd0, m_halt});
    check("tohost_o", tohost, m_tohost);
    if (ce && !we) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) check(e.name, dout, e.exp);
        $display("load  addr=%h data=%h exp=%h %s", addr, dout, e.exp, e.name);
      end
    end else if (!ce) begin
      check("idle_data_o", dout, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  // Called 1 time unit after a rising edge; returns 1 time unit after the next.
  task automatic access(input bit c, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input string nm);
    int   cl, ix;
    exp_t e;
    ce = c; we = w; addr = a; din = d;
    cl = addr_class(a);
    ix = (cl == 0) ? addr_index(a) : 0;
    if (c && !w) begin
      e.name = nm;
      e.chk  = 1'b1;
      case (cl)
        0: begin e.exp = m_mem[ix]; e.chk = m_known[ix]; end
        1: e.exp = m_tohost;
        default: e.exp = 32'd0;
      endcase
      sb_q.push_back(e);
    end else if (c && w) begin
      $display("store addr=%h data=%h %s", a, d, nm);
    end
    @(posedge clk);
    p_valid = 1'b0;
    if (c) begin
      if (cl == 0 && w) begin
        p_valid = 1'b1; p_idx = ix; p_old = m_mem[ix]; p_known = m_known[ix];
        m_mem[ix] = d; m_known[ix] = 1'b1;
      end else if (cl == 1 && w) begin
        m_tohost = d;
        if (d[0]) m_halt = 1'b1;
      end else if (cl == 2) begin
        if (!m_err) m_err_addr = a;
        m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(1'b0, 1'b0, $urandom, $urandom, "idle");
  endtask

  // Holds reset across one rising edge.
  task automatic do_reset();
    ce = 1'b0;
    rst = 1'b0;
    m_err = 1'b0; m_err_addr = '0; m_halt = 1'b0; m_tohost = '0;
    if (p_valid) begin
      m_mem[p_idx] = p_old; m_known[p_idx] = p_known;
    end
    p_valid = 1'b0;
    $display("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    m_err = 1'b0; m_err_addr = '0; m_halt = 1'b0; m_tohost = '0; p_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // preload words used by the directed cases
    access(1, 1, 32'h0000_0000, 32'h0BAD_F00D, "pre0");
    access(1, 1, 32'h0000_0FFC, 32'h5A5A_0FFC, "pre_ffc");
    access(1, 1, 32'h0000_0040, 32'hAAAA_5555, "pre40");
    idle(1);

    // bypass then array read
    access(1, 1, 32'h10, 32'hDEAD_BEEF, "st10");
    access(1, 0, 32'h10, 32'h0, "ld10_bypass");
    idle(1);
    access(1, 0, 32'h10, 32'h0, "ld10_array");

    // back-to-back stores to the same word
    access(1, 1, 32'h20, 32'h1111_1111, "st20a");
    access(1, 1, 32'h20, 32'h2222_2222, "st20b");
    idle(2);
    access(1, 0, 32'h20, 32'h0, "ld20");

    // misaligned load, then out-of-map store must not alias into RAM
    access(1, 0, 32'h13, 32'h0, "ld13_misaligned");
    access(1, 1, 32'h5000, 32'hFFFF_0000, "st5000");
    idle(1);
    access(1, 0, 32'h0, 32'h0, "ld0_unchanged");

    // tohost
    access(1, 1, TOHOST, 32'h2, "tohost2");
    access(1, 1, TOHOST, 32'h1, "tohost1");
    access(1, 0, TOHOST, 32'h0, "ld_tohost");

    // pending store lost on reset
    access(1, 1, 32'h40, 32'hCAFE_F00D, "st40");
    do_reset();
    access(1, 0, 32'h40, 32'h0, "ld40_after_reset");

    // range boundary
    access(1, 0, BASE + 32'(4 * DEPTH), 32'h0, "ld_past_end");
    access(1, 0, 32'h0FFC, 32'h0, "ld_last_word");
    access(1, 0, 32'hFFFF_FFFC, 32'h0, "ld_top_of_space");

    // randomized traffic
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      int          sel;
      logic [31:0] a;
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2, 3, 4, 5: a = BASE + 32'($urandom_range(0, 15) * 4);
          6:       a = TOHOST;
          7:       a = 32'h0000_0FFC;
          8: begin
            case ($urandom_range(0, 3))
              0: a = 32'h0000_1000;
              1: a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
              2: a = 32'hFFFF_FFFC;
              default: a = 32'h0000_5000;
            endcase
          end
          default: a = $urandom;
        endcase
        access($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom, "rnd");
      end
    end

    idle(2);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
